adder_share_arbiter: RTL

- Shares one adder4_gate-style datapath (4-bit operands a/b, start pulse in, done out, sum out) among NREQ software/HW requesters.
- Round-robin arbitration, operand capture, start sequencing, done detection with timeout, result return to the granted requester.
- Sits between requester-side transactors (e.g. DPI task front-ends) and the shared gate-level adder instance in top.

---
 rtl/adder_share_pkg.sv | 21 ++
 rtl/adder_share_arbiter_if.sv | 33 +++
 rtl/adder_share_arbiter_rr_arbiter.sv | 52 +++++
 rtl/adder_share_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - default sizes and FSM encoding shared by the adder sharing arbiter
package adder_share_pkg;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_TIMEOUT   = 31;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - requester and shared-adder signals of the adder sharing arbiter
interface adder_share_arbiter_if
    import adder_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_start;
    logic              add_done;
    logic [W-1:0]      add_s;
    logic              busy;

    modport slave (
        input  req, a_in, b_in, add_done, add_s,
        output gnt, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start, busy
    );

    modport master (
        output req, a_in, b_in, add_done, add_s,
        input  gnt, rsp_valid, rsp_sum, rsp_err, add_a, add_b, add_start, busy
    );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// rtl/adder_share_arbiter_rr_arbiter.sv - round-robin requester selection with its rotating pointer
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = clog2_min1(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             update,
    input  logic [IDX_W-1:0] last_idx,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] ptr;

    // Pointer moves just past the requester that was last served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (update) begin
            if (last_idx == IDX_W'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= last_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - time-shares one start/done adder among NREQ round-robin requesters
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int W         = DEF_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_share_arbiter_if.slave  bus
);

    localparam int IDX_W   = clog2_min1(NREQ);
    localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             done_meta;
    logic             done_s;
    logic             completed;
    logic             timed_out;
    logic             setup_done;

    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [W-1:0]     rsp_sum_q;
    logic             rsp_err_q;
    logic [W-1:0]     add_a_q;
    logic [W-1:0]     add_b_q;
    logic             add_start_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req),
        .update   (state == ST_RESP),
        .last_idx (gnt_idx),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= bus.add_done;
            done_s    <= done_meta;
        end
    end

    // A done level left over from the previous operation must be seen low before it counts.
    assign completed  = armed && done_s;
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));
    assign setup_done = (cnt == CNT_W'(SETUP_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx     <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_err_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_start_q <= 1'b0;
            cnt         <= '0;
            armed       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q       <= arb_gnt;
                        gnt_idx     <= arb_idx;
                        add_a_q     <= bus.a_in[arb_idx*W +: W];
                        add_b_q     <= bus.b_in[arb_idx*W +: W];
                        add_start_q <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_done) begin
                        cnt         <= '0;
                        armed       <= 1'b0;
                        add_start_q <= 1'b1;
                        state       <= ST_START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    armed <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!done_s) begin
                        armed <= 1'b1;
                    end
                    if (completed) begin
                        rsp_sum_q   <= bus.add_s;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q;
                        add_start_q <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timed_out) begin
                        rsp_sum_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        add_start_q <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    gnt_q <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    add_start_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_start = add_start_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule
